// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix datapath blocks.
package matrix_pkg;

  typedef enum logic [1:0] {
    DA_IDLE,
    DA_CLEAR,
    DA_MAC,
    DA_DONE
  } dot_state_t;

  localparam int BYTE_W = 8;

  // Accumulator width that cannot overflow for size products of two full-scale bytes.
  function automatic int acc_width(input int size);
    return 2 * BYTE_W + $clog2(size);
  endfunction

endpackage

// File: rtl/dot_accumulator_mac_unit.sv
// Registered multiply-accumulate datapath: acc <= acc + a*b while enabled,
// cleared by clr. The unsigned 8x8 product is zero-extended to the accumulator width.
module mac_unit
  import matrix_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] a_in,
  input  logic [BYTE_W-1:0] b_in,
  input  logic              clr,
  input  logic              en,
  output logic [ACC_W-1:0]  acc
);

  logic [2*BYTE_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_q;

  assign prod = a_in * b_in;

  // Next accumulator value: clear wins over accumulate, otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_accumulator.sv
// Sequences the row/column byte muxes and accumulates SIZE byte products into
// one unsigned dot product, handed off with a valid/ready handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   DA_IDLE  | waiting for start; all control outputs low
//   DA_CLEAR | reset mux counters, zero accumulator and element index
//   DA_MAC   | muxes enabled and stepping; accumulate one product per cycle
//   DA_DONE  | result_valid high, result held until result_ready
module dot_accumulator
  import matrix_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int ACC_W = acc_width(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] a_in,
  input  logic [BYTE_W-1:0] b_in,
  output logic              mux_reset,
  output logic              mux_enable,
  output logic              mux_next,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  dot_state_t       state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             mux_reset_d, mux_reset_q;
  logic             mux_enable_d, mux_enable_q;
  logic             busy_d, busy_q;
  logic             valid_d, valid_q;
  logic             mac_clr;
  logic             mac_en;

  // Next-state logic; Moore outputs are decoded from the next state so they
  // can be registered and still line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      DA_IDLE: begin
        if (start) state_d = DA_CLEAR;
      end
      DA_CLEAR: begin
        idx_d   = '0;
        state_d = DA_MAC;
      end
      DA_MAC: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = DA_DONE;
      end
      DA_DONE: begin
        if (result_ready) state_d = start ? DA_CLEAR : DA_IDLE;
      end
      default: state_d = DA_IDLE;
    endcase

    mux_reset_d  = (state_d == DA_CLEAR);
    mux_enable_d = (state_d == DA_MAC);
    busy_d       = (state_d != DA_IDLE);
    valid_d      = (state_d == DA_DONE);
  end

  // State, index and registered control outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DA_IDLE;
      idx_q        <= '0;
      mux_reset_q  <= 1'b0;
      mux_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mux_reset_q  <= mux_reset_d;
      mux_enable_q <= mux_enable_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  // The mux counter is zero after CLEAR and steps on every MAC edge, so the
  // operands seen in MAC cycle i are element i.
  assign mac_clr = (state_q == DA_CLEAR);
  assign mac_en  = (state_q == DA_MAC);

  mac_unit #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .a_in (a_in),
    .b_in (b_in),
    .clr  (mac_clr),
    .en   (mac_en),
    .acc  (result)
  );

  assign mux_reset    = mux_reset_q;
  assign mux_enable   = mux_enable_q;
  assign mux_next     = mux_enable_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Bench for dot_accumulator with two behavioural 4-byte mux stages feeding it.
module tb_dot_accumulator;

  localparam int SIZE  = 4;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       a_in, b_in;
  logic             mux_reset, mux_enable, mux_next;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;

  logic [SIZE-1:0][7:0] a_vec, b_vec;
  logic [1:0]           a_cnt, b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_accumulator #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .mux_reset   (mux_reset),
    .mux_enable  (mux_enable),
    .mux_next    (mux_next),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  // Row and column byte-select muxes.
  always_ff @(posedge clk) begin
    if (reset || mux_reset) begin
      a_cnt <= 2'd0;
      b_cnt <= 2'd0;
    end else begin
      if (mux_enable && mux_next) a_cnt <= a_cnt + 2'd1;
      if (mux_enable && mux_next) b_cnt <= b_cnt + 2'd1;
    end
  end
  assign a_in = a_vec[a_cnt];
  assign b_in = b_vec[b_cnt];

  function automatic logic [63:0] dot_ref(input logic [SIZE-1:0][7:0] a, input logic [SIZE-1:0][7:0] b);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < SIZE; i++) s = s + 64'(a[i]) * 64'(b[i]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input bit r, input bit e, input bit b, input bit v);
    chk({tag, ".mux_reset"}, 64'(mux_reset), 64'(r));
    chk({tag, ".mux_enable"}, 64'(mux_enable), 64'(e));
    chk({tag, ".mux_next"}, 64'(mux_next), 64'(e));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".result_valid"}, 64'(result_valid), 64'(v));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One dot product from IDLE, or from DONE when the previous op was chained.
  // hold: cycles spent in DONE with result_ready low and start toggling.
  // chain: leave the op in DONE so the next call accepts with start&ready.
  task automatic run_op(input string tag, input logic [SIZE-1:0][7:0] a,
                        input logic [SIZE-1:0][7:0] b, input int hold, input bit chain);
    logic [63:0] exp;
    exp          = dot_ref(a, b);
    a_vec        = a;
    b_vec        = b;
    start        = 1'b1;
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    chk_ctl({tag, ".clear"}, 1, 0, 1, 0);
    for (int k = 1; k <= SIZE; k++) begin
      start = 1'($urandom);
      cyc();
      chk_ctl({tag, ".mac"}, 0, 1, 1, 0);
    end
    start = 1'($urandom);
    cyc();
    chk_ctl({tag, ".done"}, 0, 0, 1, 1);
    chk({tag, ".result"}, 64'(result), exp);
    for (int h = 0; h < hold; h++) begin
      start        = ~start;
      result_ready = 1'b0;
      cyc();
      chk_ctl({tag, ".hold"}, 0, 0, 1, 1);
      chk({tag, ".hold_result"}, 64'(result), exp);
    end
    if (!chain) begin
      start        = 1'b0;
      result_ready = 1'b1;
      cyc();
      result_ready = 1'b0;
      chk_ctl({tag, ".idle"}, 0, 0, 0, 0);
      chk({tag, ".idle_result"}, 64'(result), exp);
    end
  endtask

  initial begin
    logic [SIZE-1:0][7:0] ra, rb;
    reset        = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    a_vec        = '0;
    b_vec        = '0;
    cyc();
    cyc();
    chk_ctl("reset", 0, 0, 0, 0);
    chk("reset.result", 64'(result), 64'd0);
    reset = 1'b0;
    cyc();
    chk_ctl("idle0", 0, 0, 0, 0);

    run_op("t1", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0, 0);
    run_op("t2", {4{8'd255}}, {4{8'd255}}, 0, 0);
    run_op("t3", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 5, 1);
    run_op("t4", {8'd9, 8'd0, 8'd0, 8'd0}, {8'd9, 8'd0, 8'd0, 8'd0}, 0, 0);

    // Reset during the second MAC cycle aborts the operation.
    a_vec = {8'd4, 8'd3, 8'd2, 8'd1};
    b_vec = {8'd8, 8'd7, 8'd6, 8'd5};
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk_ctl("t5.mac2", 0, 1, 1, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_ctl("t5.abort", 0, 0, 0, 0);
    chk("t5.abort_result", 64'(result), 64'd0);
    cyc();
    chk_ctl("t5.stay_idle", 0, 0, 0, 0);
    run_op("t5.fresh", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0, 0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < SIZE; i++) begin
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
      end
      run_op("rnd", ra, rb, int'($urandom_range(0, 3)), (r != 9) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
